// File: rtl/slot_perst_pkg.sv
// Shared state encodings and default timing for the slot PERST# sequencer.
package slot_perst_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PWR_ON = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_OFF    = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    localparam int unsigned DEF_PWRGD_TIMEOUT = 200000;
    localparam int unsigned DEF_T_PVPERL      = 200000;
    localparam int unsigned DEF_T_OFF         = 2000;

    // Largest of three timing values; sizes the shared counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/slot_perst_seq_if.sv
// Platform-side control/status bundle of the slot sequencer.
interface slot_perst_seq_if;

    logic       iPwrReq;
    logic       iPerstIn_n;
    logic       iSlotPwrgd;
    logic       iForceOff;
    logic       oSlotPwrEn;
    logic       oPerst_n;
    logic       oFault;
    logic [2:0] oState;

    modport master (
        output iPwrReq, iPerstIn_n, iSlotPwrgd, iForceOff,
        input  oSlotPwrEn, oPerst_n, oFault, oState
    );

    modport slave (
        input  iPwrReq, iPerstIn_n, iSlotPwrgd, iForceOff,
        output oSlotPwrEn, oPerst_n, oFault, oState
    );

endinterface

// File: rtl/slot_perst_seq_timer.sv
// Clearable, saturating cycle counter with a terminal-count compare.
module seq_timer #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] tc,
    output logic             tc_hit
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_hit = (cnt_q == tc);

endmodule

// File: rtl/slot_perst_seq.sv
// Slot power / PERST# sequencer: power-good wait, PERST# hold-off,
// orderly power-down and sticky fault handling.
module slot_perst_seq
    import slot_perst_pkg::*;
#(
    parameter int unsigned PWRGD_TIMEOUT = DEF_PWRGD_TIMEOUT,
    parameter int unsigned T_PVPERL      = DEF_T_PVPERL,
    parameter int unsigned T_OFF         = DEF_T_OFF
) (
    input  logic           iClk,
    input  logic           iRst_n,
    slot_perst_seq_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(max3(PWRGD_TIMEOUT, T_PVPERL, T_OFF) + 1);
    localparam logic [CNT_W-1:0] TC_PWRGD = CNT_W'(PWRGD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TC_PVPERL = CNT_W'(T_PVPERL - 1);
    localparam logic [CNT_W-1:0] TC_OFF    = CNT_W'(T_OFF - 1);

    state_e           state_q, state_d;
    logic             pwr_en_q, pwr_en_d;
    logic             perst_n_q, perst_n_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] tc_sel;
    logic             tc_hit;
    logic             tmr_clr;
    logic             stop_req;

    assign stop_req = bus.iForceOff || !bus.iPwrReq;

    // Terminal count for the timed state currently occupied.
    always_comb begin
        tc_sel = '0;
        case (state_q)
            ST_PWR_ON: tc_sel = TC_PWRGD;
            ST_STABLE: tc_sel = TC_PVPERL;
            ST_OFF:    tc_sel = TC_OFF;
            default:   tc_sel = '0;
        endcase
    end

    seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk    (iClk),
        .rst_n  (iRst_n),
        .clr    (tmr_clr),
        .tc     (tc_sel),
        .tc_hit (tc_hit)
    );

    // Next state, timer clear and next registered outputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.iPwrReq && !bus.iForceOff) state_d = ST_PWR_ON;
            ST_PWR_ON: begin
                if (stop_req)             state_d = ST_OFF;
                else if (bus.iSlotPwrgd)  state_d = ST_STABLE;
                else if (tc_hit)          state_d = ST_FAULT;
            end
            ST_STABLE: begin
                if (!bus.iSlotPwrgd)      state_d = ST_FAULT;
                else if (stop_req)        state_d = ST_OFF;
                else if (tc_hit)          state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!bus.iSlotPwrgd)      state_d = ST_FAULT;
                else if (stop_req)        state_d = ST_OFF;
            end
            ST_OFF:    if (tc_hit) state_d = ST_IDLE;
            ST_FAULT:  if (!bus.iPwrReq && !bus.iForceOff) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        tmr_clr = (state_d != state_q) || (state_q == ST_IDLE);

        pwr_en_d  = (state_d == ST_PWR_ON) || (state_d == ST_STABLE) ||
                    (state_d == ST_RUN)    || (state_d == ST_OFF);
        // PERST# only passes through once RUN has been held for a cycle,
        // so it rises one cycle after RUN entry and drops with any exit.
        perst_n_d = (state_q == ST_RUN) && (state_d == ST_RUN) && bus.iPerstIn_n;
        fault_d   = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q   <= ST_IDLE;
            pwr_en_q  <= 1'b0;
            perst_n_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwr_en_q  <= pwr_en_d;
            perst_n_q <= perst_n_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.oSlotPwrEn = pwr_en_q;
    assign bus.oPerst_n   = perst_n_q;
    assign bus.oFault     = fault_q;
    assign bus.oState     = state_q;

endmodule

// File: tb/tb_slot_perst_seq.sv
// Bench for slot_perst_seq: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the sequencing rules.
module tb_slot_perst_seq;

    localparam int unsigned PWRGD_TIMEOUT = 8;
    localparam int unsigned T_PVPERL      = 4;
    localparam int unsigned T_OFF         = 3;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Model: phase (spec state code), cycles spent in the phase, outputs.
    int   m_ph;
    int   m_t;
    int   m_pwren;
    int   m_perst;
    int   m_fault;
    int   m_streak;

    slot_perst_seq_if bus ();

    slot_perst_seq #(
        .PWRGD_TIMEOUT (PWRGD_TIMEOUT),
        .T_PVPERL      (T_PVPERL),
        .T_OFF         (T_OFF)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply the sequencing rules to the inputs seen at this clock edge.
    task automatic model_step();
        int nph;
        logic req, frc, pg;
        req = bus.iPwrReq;
        frc = bus.iForceOff;
        pg  = bus.iSlotPwrgd;
        m_streak = pg ? m_streak + 1 : 0;
        if (!rst_n) begin
            m_ph = 0; m_t = 0; m_pwren = 0; m_perst = 0; m_fault = 0;
            return;
        end
        nph = m_ph;
        case (m_ph)
            0: if (req && !frc) nph = 1;
            1: if (frc || !req) nph = 4;
               else if (pg) nph = 2;
               else if (m_t == PWRGD_TIMEOUT - 1) nph = 5;
            2: if (!pg) nph = 5;
               else if (frc || !req) nph = 4;
               else if (m_t == T_PVPERL - 1) nph = 3;
            3: if (!pg) nph = 5;
               else if (frc || !req) nph = 4;
            4: if (m_t == T_OFF - 1) nph = 0;
            5: if (!req && !frc) nph = 0;
            default: nph = 0;
        endcase
        m_perst = (m_ph == 3 && nph == 3) ? int'(bus.iPerstIn_n) : 0;
        m_t     = (nph != m_ph) ? 0 : m_t + 1;
        m_ph    = nph;
        m_pwren = (nph >= 1 && nph <= 4) ? 1 : 0;
        m_fault = (nph == 5) ? 1 : 0;
    endtask

    // One clock: model update on the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("m_state", int'(bus.oState), m_ph);
        chk("m_pwren", int'(bus.oSlotPwrEn), m_pwren);
        chk("m_perst", int'(bus.oPerst_n), m_perst);
        chk("m_fault", int'(bus.oFault), m_fault);
        if (bus.oPerst_n)
            chk("perst_gate", int'(m_streak >= int'(T_PVPERL) && bus.oState == 3'd3), 1);
    endtask

    task automatic bring_up();
        bus.iPwrReq = 1'b1; bus.iSlotPwrgd = 1'b1; bus.iForceOff = 1'b0;
        bus.iPerstIn_n = 1'b1;
        for (int i = 0; i < 40 && !(bus.oState == 3'd3 && bus.oPerst_n); i++) tick();
        chk("bringup_run", int'(bus.oState), 3);
        chk("bringup_perst", int'(bus.oPerst_n), 1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_ph = 0; m_t = 0; m_pwren = 0; m_perst = 0; m_fault = 0; m_streak = 0;
        rst_n = 1'b0;
        bus.iPwrReq = 1'b0; bus.iPerstIn_n = 1'b0;
        bus.iSlotPwrgd = 1'b0; bus.iForceOff = 1'b0;
        @(negedge clk);
        tick(); tick();
        chk("rst_state", int'(bus.oState), 0);
        chk("rst_pwren", int'(bus.oSlotPwrEn), 0);
        chk("rst_perst", int'(bus.oPerst_n), 0);
        chk("rst_fault", int'(bus.oFault), 0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", int'(bus.oState), 0);

        // Normal power-up
        bus.iPwrReq = 1'b1; bus.iPerstIn_n = 1'b1;
        tick();
        chk("up_pwron", int'(bus.oState), 1);
        chk("up_pwren", int'(bus.oSlotPwrEn), 1);
        tick();
        chk("up_wait", int'(bus.oState), 1);
        bus.iSlotPwrgd = 1'b1;
        tick();
        chk("up_stable", int'(bus.oState), 2);
        repeat (3) tick();
        chk("up_stable_hold", int'(bus.oState), 2);
        chk("up_perst_low", int'(bus.oPerst_n), 0);
        tick();
        chk("up_run", int'(bus.oState), 3);
        chk("up_perst_lat", int'(bus.oPerst_n), 0);
        tick();
        chk("up_perst_rel", int'(bus.oPerst_n), 1);

        // PERST# pass-through in RUN
        bus.iPerstIn_n = 1'b0;
        tick();
        chk("pass_low", int'(bus.oPerst_n), 0);
        bus.iPerstIn_n = 1'b1;
        tick();
        chk("pass_high", int'(bus.oPerst_n), 1);

        // Orderly off, with a request reassert that must not abort it
        bus.iPwrReq = 1'b0;
        tick();
        chk("off_perst", int'(bus.oPerst_n), 0);
        chk("off_state", int'(bus.oState), 4);
        bus.iPwrReq = 1'b1;
        tick(); tick();
        chk("off_pwren_hold", int'(bus.oSlotPwrEn), 1);
        chk("off_state_hold", int'(bus.oState), 4);
        tick();
        chk("off_pwren_drop", int'(bus.oSlotPwrEn), 0);
        chk("off_idle", int'(bus.oState), 0);

        // Power-good glitch in RUN
        bring_up();
        bus.iSlotPwrgd = 1'b0;
        tick();
        chk("glitch_perst", int'(bus.oPerst_n), 0);
        chk("glitch_pwren", int'(bus.oSlotPwrEn), 0);
        chk("glitch_fault", int'(bus.oFault), 1);
        bus.iSlotPwrgd = 1'b1;
        tick();
        chk("fault_sticky", int'(bus.oFault), 1);
        bus.iPwrReq = 1'b0;
        tick();
        chk("fault_exit", int'(bus.oState), 0);
        chk("fault_clear", int'(bus.oFault), 0);

        // Power-good loss and request drop on the same cycle
        bring_up();
        bus.iSlotPwrgd = 1'b0; bus.iPwrReq = 1'b0;
        tick();
        chk("simul_fault", int'(bus.oState), 5);
        tick();
        chk("simul_exit", int'(bus.oState), 0);

        // Power-good timeout
        bus.iPwrReq = 1'b1; bus.iSlotPwrgd = 1'b0;
        tick();
        chk("to_pwron", int'(bus.oState), 1);
        repeat (PWRGD_TIMEOUT - 1) tick();
        chk("to_wait", int'(bus.oState), 1);
        tick();
        chk("to_fault", int'(bus.oState), 5);
        chk("to_fault_flag", int'(bus.oFault), 1);
        chk("to_pwren", int'(bus.oSlotPwrEn), 0);
        bus.iPwrReq = 1'b0;
        tick();
        chk("to_idle", int'(bus.oState), 0);
        chk("to_clear", int'(bus.oFault), 0);

        // Reset mid-STABLE
        bus.iPwrReq = 1'b1; bus.iSlotPwrgd = 1'b1;
        tick(); tick(); tick();
        chk("mid_stable", int'(bus.oState), 2);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_state", int'(bus.oState), 0);
        chk("mid_rst_pwren", int'(bus.oSlotPwrEn), 0);
        chk("mid_rst_perst", int'(bus.oPerst_n), 0);
        chk("mid_rst_fault", int'(bus.oFault), 0);
        rst_n = 1'b1;

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(199) != 0);
            if ($urandom_range(99) < 4) bus.iPwrReq = ~bus.iPwrReq;
            if (bus.iSlotPwrgd) bus.iSlotPwrgd = ($urandom_range(99) >= 3);
            else                bus.iSlotPwrgd = ($urandom_range(99) < 30);
            bus.iForceOff  = ($urandom_range(99) < 2);
            bus.iPerstIn_n = ($urandom_range(99) < 85);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slot_perst_seq.md
SLOT_PERST_SEQ -- requirements
Module: slot_perst_seq

Interface
REQ-001 Parameter PWRGD_TIMEOUT, default 200000, cycles allowed from oSlotPwrEn rising to iSlotPwrgd high.
REQ-002 Parameter T_PVPERL, default 200000, cycles iSlotPwrgd must stay high before PERST release (100 ms at 2 MHz).
REQ-003 Parameter T_OFF, default 2000, cycles PERST stays asserted before slot power is removed.
REQ-004 iClk  input  1  system clock; single clock domain.
REQ-005 iRst_n  input  1  synchronous, active-low reset.
REQ-006 iPwrReq  input  1  high requests slot powered and running; low requests orderly shutdown.
REQ-007 iPerstIn_n  input  1  upstream PERST# from the platform reset logic; passed through only in RUN.
REQ-008 iSlotPwrgd  input  1  slot power-good from the slot regulator.
REQ-009 iForceOff  input  1  platform-level emergency shutdown request.
REQ-010 oSlotPwrEn  output  1  slot power enable; registered.
REQ-011 oPerst_n  output  1  PERST# to the slot device; registered; low = reset.
REQ-012 oFault  output  1  sticky fault flag; registered.
REQ-013 oState  output  3  current FSM state encoding, for debug.

Function
REQ-014 FSM states: IDLE=0, PWR_ON=1, STABLE=2, RUN=3, OFF=4, FAULT=5; codes 6 and 7 SHALL recover to IDLE on the next cycle.
REQ-015 All outputs SHALL be registered and reflect the state entered, one cycle after the triggering input.
REQ-016 IDLE: oSlotPwrEn=0, oPerst_n=0. Go to PWR_ON when iPwrReq=1 and iForceOff=0. Clear the counter.
REQ-017 PWR_ON: oSlotPwrEn=1, oPerst_n=0. Priority order:
- iForceOff=1 or iPwrReq=0 -> OFF.
- iSlotPwrgd=1 -> STABLE, clear the counter.
- Counter reaches PWRGD_TIMEOUT-1 -> FAULT.
- Otherwise increment the counter.
REQ-018 STABLE: oSlotPwrEn=1, oPerst_n=0. Priority order:
- iSlotPwrgd=0 -> FAULT.
- iForceOff=1 or iPwrReq=0 -> OFF.
- Counter reaches T_PVPERL-1 -> RUN.
- Otherwise increment the counter.
REQ-019 RUN: oSlotPwrEn=1, oPerst_n = iPerstIn_n registered (1-cycle latency). Priority order:
- iSlotPwrgd=0 -> FAULT.
- iForceOff=1 or iPwrReq=0 -> OFF.
REQ-020 OFF: oSlotPwrEn=1, oPerst_n=0, counter runs. At T_OFF-1 -> IDLE, so oSlotPwrEn falls exactly T_OFF cycles after oPerst_n falls. iPwrReq reasserting during OFF SHALL NOT abort the OFF sequence.
REQ-021 FAULT: oSlotPwrEn=0, oPerst_n=0, oFault=1. Stay until iPwrReq=0 and iForceOff=0, then go to IDLE; oFault clears on leaving FAULT.
REQ-022 A power-good loss SHALL drive oPerst_n and oSlotPwrEn low on the same registered edge; there is no T_OFF delay in FAULT.
REQ-023 The counter SHALL be sized from the largest of the three parameters, never wrap, and clear on every state change.
REQ-024 oPerst_n SHALL never be high unless the state is RUN and iSlotPwrgd has been continuously high for at least T_PVPERL cycles.

Reset
REQ-025 While iRst_n=0 at a clock edge: state IDLE, counter 0, oSlotPwrEn=0, oPerst_n=0, oFault=0, oState=0.
REQ-026 Reset asserted mid-sequence, in any state, SHALL force the REQ-025 values on the next edge; there is no orderly T_OFF sequence.

Structure
REQ-027 Package slot_perst_pkg SHALL hold the state encodings and the default timing constants.
REQ-028 One sub-module, seq_timer, SHALL provide the clearable, saturating cycle counter with a terminal-count compare; the FSM SHALL be the only other logic.

Verification (parameters PWRGD_TIMEOUT=8, T_PVPERL=4, T_OFF=3)
REQ-029 Normal power-up: iPwrReq=1, then iSlotPwrgd=1 two cycles after oSlotPwrEn=1, iPerstIn_n=1. Required: oPerst_n=1 exactly 4+1 cycles after STABLE entry, and oState sequence 0,1,2,3.
REQ-030 Power-good timeout: iPwrReq=1, iSlotPwrgd held 0. Required: FAULT after 8 cycles in PWR_ON, oFault=1, oSlotPwrEn=0; after iPwrReq=0, IDLE and oFault=0.
REQ-031 Orderly off: in RUN, drop iPwrReq. Required: oPerst_n=0 next cycle, oSlotPwrEn=0 exactly 3 cycles later, state IDLE.
REQ-032 Power-good glitch: in RUN, iSlotPwrgd=0 for 1 cycle. Required: oPerst_n=0, oSlotPwrEn=0 and oFault=1 on the same edge.
REQ-033 Simultaneous events: iSlotPwrgd=0 and iPwrReq=0 in the same RUN cycle. Required: FAULT, not OFF.
REQ-034 Reset mid-STABLE and iPerstIn_n toggling in RUN: reset gives all outputs 0 next cycle; in RUN, oPerst_n follows iPerstIn_n with 1-cycle latency.
